// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RISC-V execute stage: forwarding, ALU, beq resolution, EX/MEM register
//
// Purpose:
//   Selects forwarded operands, runs the ALU, resolves beq combinationally
//   (PC_Exmux / PCtarget_E back to fetch) and registers results into the
//   execute/memory pipeline register.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   *_E inputs            decode/execute pipeline signals
//   fwdA_E, fwdB_E        00/11 = RDx_E, 01 = Result_W, 10 = ALUresult_M
//   Result_W              writeback value for forwarding
//   stall_M, flush_M      hold / bubble the execute/memory register (flush wins)
//   PC_Exmux, PCtarget_E  branch taken and branch target (combinational)
//   *_M outputs           execute/memory register contents
//
// Optional feature macro: EXEC_SLT_EN (ALU code 0101 = signed set-less-than).

module execute_cycle #(
    parameter int XLEN = 32,
    parameter int REGA = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regwrt_E,
    input  logic            memwrite_E,
    input  logic            resultctrl_E,
    input  logic            branch_E,
    input  logic            oprsel_E,
    input  logic [3:0]      ALUcontrol_E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] immdx_E,
    input  logic [XLEN-1:0] PC_DE,
    input  logic [XLEN-1:0] PC_1DE,
    input  logic [REGA-1:0] RD_E,
    input  logic [1:0]      fwdA_E,
    input  logic [1:0]      fwdB_E,
    input  logic [XLEN-1:0] Result_W,
    input  logic            stall_M,
    input  logic            flush_M,
    output logic            PC_Exmux,
    output logic [XLEN-1:0] PCtarget_E,
    output logic            regwrt_M,
    output logic            memwrite_M,
    output logic            resultctrl_M,
    output logic [XLEN-1:0] ALUresult_M,
    output logic [XLEN-1:0] WriteData_M,
    output logic [XLEN-1:0] PC_1M,
    output logic [REGA-1:0] RD_M,
    output logic            zero_M
);

    logic            regwrt_d, regwrt_q;
    logic            memwrite_d, memwrite_q;
    logic            resultctrl_d, resultctrl_q;
    logic            zero_d, zero_q;
    logic [XLEN-1:0] alu_d, alu_q;
    logic [XLEN-1:0] wdata_d, wdata_q;
    logic [XLEN-1:0] pc1_d, pc1_q;
    logic [REGA-1:0] rd_d, rd_q;

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res;
    logic            alu_zero;

    // Forward select 10 feeds back the live register value, stalled or not.
    always_comb begin
        case (fwdA_E)
            2'b01:   src_a = Result_W;
            2'b10:   src_a = alu_q;
            default: src_a = RD1_E;
        endcase
        case (fwdB_E)
            2'b01:   fwd_b = Result_W;
            2'b10:   fwd_b = alu_q;
            default: fwd_b = RD2_E;
        endcase
        src_b = oprsel_E ? immdx_E : fwd_b;
    end

    always_comb begin
        case (ALUcontrol_E)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a ^ src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a & src_b;
`ifdef EXEC_SLT_EN
            4'b0101: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`endif
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == '0);
    end

    assign PC_Exmux   = branch_E & alu_zero & rst;
    assign PCtarget_E = PC_DE + immdx_E;

    // Flush clears only the control bits; data fields capture as normal.
    always_comb begin
        regwrt_d     = regwrt_q;
        memwrite_d   = memwrite_q;
        resultctrl_d = resultctrl_q;
        zero_d       = zero_q;
        alu_d        = alu_q;
        wdata_d      = wdata_q;
        pc1_d        = pc1_q;
        rd_d         = rd_q;
        if (flush_M || !stall_M) begin
            alu_d   = alu_res;
            wdata_d = fwd_b;
            pc1_d   = PC_1DE;
            rd_d    = RD_E;
            if (flush_M) begin
                regwrt_d     = 1'b0;
                memwrite_d   = 1'b0;
                resultctrl_d = 1'b0;
                zero_d       = 1'b0;
            end else begin
                regwrt_d     = regwrt_E;
                memwrite_d   = memwrite_E;
                resultctrl_d = resultctrl_E;
                zero_d       = alu_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrt_q     <= 1'b0;
            memwrite_q   <= 1'b0;
            resultctrl_q <= 1'b0;
            zero_q       <= 1'b0;
            alu_q        <= '0;
            wdata_q      <= '0;
            pc1_q        <= '0;
            rd_q         <= '0;
        end else begin
            regwrt_q     <= regwrt_d;
            memwrite_q   <= memwrite_d;
            resultctrl_q <= resultctrl_d;
            zero_q       <= zero_d;
            alu_q        <= alu_d;
            wdata_q      <= wdata_d;
            pc1_q        <= pc1_d;
            rd_q         <= rd_d;
        end
    end

    assign regwrt_M     = regwrt_q;
    assign memwrite_M   = memwrite_q;
    assign resultctrl_M = resultctrl_q;
    assign zero_M       = zero_q;
    assign ALUresult_M  = alu_q;
    assign WriteData_M  = wdata_q;
    assign PC_1M        = pc1_q;
    assign RD_M         = rd_q;

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - scoreboard testbench for execute_cycle

module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrt_E, memwrite_E, resultctrl_E, branch_E, oprsel_E;
    logic [3:0]  ALUcontrol_E;
    logic [31:0] RD1_E, RD2_E, immdx_E, PC_DE, PC_1DE, Result_W;
    logic [4:0]  RD_E;
    logic [1:0]  fwdA_E, fwdB_E;
    logic        stall_M, flush_M;
    logic        PC_Exmux;
    logic [31:0] PCtarget_E;
    logic        regwrt_M, memwrite_M, resultctrl_M, zero_M;
    logic [31:0] ALUresult_M, WriteData_M, PC_1M;
    logic [4:0]  RD_M;

    execute_cycle #(.XLEN(32), .REGA(5)) dut (
        .clk(clk), .rst(rst),
        .regwrt_E(regwrt_E), .memwrite_E(memwrite_E), .resultctrl_E(resultctrl_E),
        .branch_E(branch_E), .oprsel_E(oprsel_E), .ALUcontrol_E(ALUcontrol_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .immdx_E(immdx_E),
        .PC_DE(PC_DE), .PC_1DE(PC_1DE), .RD_E(RD_E),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .Result_W(Result_W),
        .stall_M(stall_M), .flush_M(flush_M),
        .PC_Exmux(PC_Exmux), .PCtarget_E(PCtarget_E),
        .regwrt_M(regwrt_M), .memwrite_M(memwrite_M), .resultctrl_M(resultctrl_M),
        .ALUresult_M(ALUresult_M), .WriteData_M(WriteData_M), .PC_1M(PC_1M),
        .RD_M(RD_M), .zero_M(zero_M)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        regwrt;
        logic        memwrite;
        logic        resultctrl;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc1;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;            // reference model of the EX/MEM register contents
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] code);
        logic [31:0] r;
        r = 32'd0;
        if (code == 4'd0) r = a + b;
        else if (code == 4'd1) r = a - b;
        else if (code == 4'd2) r = a ^ b;
        else if (code == 4'd3) r = a | b;
        else if (code == 4'd4) r = a & b;
`ifdef EXEC_SLT_EN
        else if (code == 4'd5) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
        return r;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rd);
        if (sel == 2'b01) return Result_W;
        if (sel == 2'b10) return m.alu;
        return rd;
    endfunction

    // Monitor: every clock edge with a pending expectation presents an output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("regwrt_M",     {31'd0, regwrt_M},     {31'd0, e.regwrt});
                chk("memwrite_M",   {31'd0, memwrite_M},   {31'd0, e.memwrite});
                chk("resultctrl_M", {31'd0, resultctrl_M}, {31'd0, e.resultctrl});
                chk("zero_M",       {31'd0, zero_M},       {31'd0, e.zero});
                chk("ALUresult_M",  ALUresult_M,           e.alu);
                chk("WriteData_M",  WriteData_M,           e.wd);
                chk("PC_1M",        PC_1M,                 e.pc1);
                chk("RD_M",         {27'd0, RD_M},         {27'd0, e.rd});
            end
        end
    end

    // Called right after inputs are driven at a negedge; returns at the next negedge.
    task automatic step();
        logic [31:0] a, fb, b, res;
        exp_t nx;
        #1;
        a   = pick(fwdA_E, RD1_E);
        fb  = pick(fwdB_E, RD2_E);
        b   = oprsel_E ? immdx_E : fb;
        res = ref_alu(a, b, ALUcontrol_E);
        chk("PC_Exmux",   {31'd0, PC_Exmux}, {31'd0, branch_E && res == 32'd0});
        chk("PCtarget_E", PCtarget_E, PC_DE + immdx_E);
        nx = m;
        if (flush_M || !stall_M) begin
            nx.alu = res; nx.wd = fb; nx.pc1 = PC_1DE; nx.rd = RD_E;
            nx.regwrt     = flush_M ? 1'b0 : regwrt_E;
            nx.memwrite   = flush_M ? 1'b0 : memwrite_E;
            nx.resultctrl = flush_M ? 1'b0 : resultctrl_E;
            nx.zero       = flush_M ? 1'b0 : (res == 32'd0);
        end
        exp_q.push_back(nx);
        m = nx;
        @(negedge clk);
    endtask

    task automatic base(input logic [3:0] code, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic osel);
        regwrt_E = 1'b1; memwrite_E = 1'b0; resultctrl_E = 1'b0; branch_E = 1'b0;
        ALUcontrol_E = code; RD1_E = r1; RD2_E = r2; immdx_E = imm; oprsel_E = osel;
        fwdA_E = 2'b00; fwdB_E = 2'b00; stall_M = 1'b0; flush_M = 1'b0;
        PC_DE = 32'h40; PC_1DE = 32'h44; RD_E = 5'd3; Result_W = 32'd0;
    endtask

    task automatic rand_inputs();
        regwrt_E = 1'($urandom); memwrite_E = 1'($urandom); resultctrl_E = 1'($urandom);
        branch_E = 1'($urandom); oprsel_E = 1'($urandom);
        ALUcontrol_E = 4'($urandom_range(0, 7));
        RD1_E = $urandom; RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
        immdx_E = $urandom; PC_DE = $urandom; PC_1DE = PC_DE + 32'd4;
        RD_E = 5'($urandom); fwdA_E = 2'($urandom); fwdB_E = 2'($urandom);
        Result_W = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
        stall_M = ($urandom_range(0, 5) == 0); flush_M = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        m = '0;
        rst = 1'b0;
        base(4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        #2;
        chk("reset_alu", ALUresult_M, 32'd0);
        chk("reset_regwrt", {31'd0, regwrt_M}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // add wrap and sub wrap
        base(4'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1); step();
        chk("wrap_add", ALUresult_M, 32'd0);
        chk("wrap_zero", {31'd0, zero_M}, 32'd1);
        base(4'd1, 32'd0, 32'd1, 32'd0, 1'b0); step();
        chk("wrap_sub", ALUresult_M, 32'hFFFF_FFFF);

        // forwarding
        base(4'd0, 32'd5, 32'd0, 32'd0, 1'b1); step();
        base(4'd0, 32'd1, 32'd2, 32'd0, 1'b0);
        Result_W = 32'd7; fwdA_E = 2'b10; fwdB_E = 2'b01; step();
        chk("fwd_alu", ALUresult_M, 32'd12);
        chk("fwd_wd", WriteData_M, 32'd7);
        base(4'd0, 32'd1, 32'd2, 32'd0, 1'b0);
        Result_W = 32'd7; fwdA_E = 2'b11; fwdB_E = 2'b00; step();
        chk("fwd_rd", ALUresult_M, 32'd3);

        // branch
        base(4'd1, 32'd9, 32'd9, 32'hFFFF_FFF8, 1'b0);
        branch_E = 1'b1; PC_DE = 32'h100;
        #1;
        chk("br_taken", {31'd0, PC_Exmux}, 32'd1);
        chk("br_target", PCtarget_E, 32'hF8);
        step();
        base(4'd1, 32'd9, 32'd8, 32'hFFFF_FFF8, 1'b0);
        branch_E = 1'b1; PC_DE = 32'h100;
        #1;
        chk("br_not_taken", {31'd0, PC_Exmux}, 32'd0);
        step();

        // stall for 3 cycles with changing inputs, then stall+flush
        base(4'd0, 32'h77, 32'd0, 32'd1, 1'b1); step();
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); stall_M = 1'b1; flush_M = 1'b0; step();
            chk("stall_hold", ALUresult_M, 32'h78);
        end
        base(4'd0, 32'd1, 32'd1, 32'd0, 1'b0);
        memwrite_E = 1'b1; stall_M = 1'b1; flush_M = 1'b1; step();
        chk("flush_regwrt", {31'd0, regwrt_M}, 32'd0);
        chk("flush_memwrite", {31'd0, memwrite_M}, 32'd0);

        // optional signed set-less-than
        base(4'd5, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0); step();
`ifdef EXEC_SLT_EN
        chk("slt", ALUresult_M, 32'd1);
`else
        chk("slt_off", ALUresult_M, 32'd0);
`endif

        // asynchronous reset mid-stream
        base(4'd0, 32'h1234, 32'd0, 32'd0, 1'b1); step();
        chk("pre_reset", ALUresult_M, 32'h1234);
        base(4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        branch_E = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_alu", ALUresult_M, 32'd0);
        chk("arst_regwrt", {31'd0, regwrt_M}, 32'd0);
        chk("arst_pc1", PC_1M, 32'd0);
        chk("arst_rd", {27'd0, RD_M}, 32'd0);
        chk("arst_pcmux", {31'd0, PC_Exmux}, 32'd0);
        m = '0;
        @(negedge clk);
        rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
